fabric_temporal_fifo: RTL and testbench

// Tag-aware elastic buffer placed directly downstream of each fabric_temporal_sw output.

---
 rtl/fabric_temporal_fifo_pkg.sv | 12 +
 rtl/fabric_temporal_fifo_occupancy.sv | 41 ++++
 rtl/fabric_temporal_fifo.sv | 107 ++++++++++
 tb/tb_fabric_temporal_fifo.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fabric_temporal_fifo_pkg.sv
// fabric_temporal_fifo_pkg: error codes and pointer helper shared by the temporal FIFO files
package fabric_temporal_fifo_pkg;

    localparam logic [15:0] CFG_TEMPORAL_FIFO_CAP_GT_DEPTH  = 16'h0007;
    localparam logic [15:0] RT_TEMPORAL_FIFO_TAG_STALL_CAP0 = 16'h1007;

    // Circular increment for ring buffers whose depth need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned depth);
        return (p == depth - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/fabric_temporal_fifo_occupancy.sv
// fabric_tag_occupancy: per-tag resident-token counter bank
module fabric_tag_occupancy #(
    parameter int NUM_TAGS = 16,
    parameter int CNT_W    = 3,
    localparam int TW      = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push_i,
    input  logic [TW-1:0]                   push_tag_i,
    input  logic                            pop_i,
    input  logic [TW-1:0]                   pop_tag_i,
    output logic [NUM_TAGS-1:0][CNT_W-1:0]  tag_cnt_o
);

    logic [NUM_TAGS-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Apply push then pop sequentially so a same-tag push+pop cancels out.
    always_comb begin
        cnt_d = cnt_q;
        if (push_i) cnt_d[push_tag_i] = cnt_d[push_tag_i] + CNT_W'(1);
        if (pop_i) cnt_d[pop_tag_i] = cnt_d[pop_tag_i] - CNT_W'(1);
    end

    // Counter bank register, cleared on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

    assign tag_cnt_o = cnt_q;

`ifndef SYNTHESIS
    // A tag counter must never be decremented below zero.
    always @(posedge clk) begin
        if (rst_n && pop_i && !(push_i && push_tag_i == pop_tag_i))
            assert (cnt_q[pop_tag_i] != '0) else $error("tag_cnt underflow on tag %0d", pop_tag_i);
    end
`endif

endmodule

// File: rtl/fabric_temporal_fifo.sv
// fabric_temporal_fifo: tag-aware elastic buffer with per-tag occupancy caps and sticky config error
module fabric_temporal_fifo
    import fabric_temporal_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int TAG_WIDTH   = 4,
    parameter int DEPTH       = 4,
    localparam int NUM_TAGS   = 1 << TAG_WIDTH,
    localparam int SAFE_PW    = (DATA_WIDTH + TAG_WIDTH > 1) ? DATA_WIDTH + TAG_WIDTH : 1,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [SAFE_PW-1:0]           in_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [SAFE_PW-1:0]           out_data_o,
    input  logic [NUM_TAGS*CNT_W-1:0]    cfg_data_i,
    output logic                         error_valid_o,
    output logic [15:0]                  error_code_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    if (DEPTH < 1) begin : g_chk_depth
        $fatal(1, "CPL_TEMPORAL_FIFO_DEPTH: DEPTH must be >= 1");
    end
    if (TAG_WIDTH < 1) begin : g_chk_tag
        $fatal(1, "CPL_TEMPORAL_FIFO_TAG_WIDTH: TAG_WIDTH must be >= 1");
    end

    logic [SAFE_PW-1:0]             mem_q [DEPTH];
    logic [PTR_W-1:0]               wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]               count_q;
    logic                           error_valid_q;
    logic [15:0]                    error_code_q;
    logic [NUM_TAGS-1:0][CNT_W-1:0] tag_cnt;
    logic [TAG_WIDTH-1:0]           in_tag, out_tag;
    logic [CNT_W-1:0]               in_cap;
    logic                           push, pop, cfg_err;

    assign in_tag      = in_data_i[DATA_WIDTH +: TAG_WIDTH];
    assign out_data_o  = mem_q[rd_ptr_q];
    assign out_tag     = out_data_o[DATA_WIDTH +: TAG_WIDTH];
    assign in_cap      = cfg_data_i[int'(in_tag) * CNT_W +: CNT_W];
    assign in_ready_o  = (count_q < DEPTH_C) && (in_cap == '0 || tag_cnt[in_tag] < in_cap);
    assign out_valid_o = count_q != '0;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign error_valid_o = error_valid_q;
    assign error_code_o  = error_code_q;

    // Flag any per-tag cap that could never be reached by a DEPTH-entry buffer.
    always_comb begin
        cfg_err = 1'b0;
        for (int t = 0; t < NUM_TAGS; t++)
            cfg_err = cfg_err | (cfg_data_i[t * CNT_W +: CNT_W] > DEPTH_C);
    end

    // Storage array; contents are don't-care after reset so it is not cleared.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end

    // Pointers, occupancy count and first-error latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            error_valid_q <= 1'b0;
            error_code_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= PTR_W'(wrap_inc(int'(wr_ptr_q), DEPTH));
            if (pop) rd_ptr_q <= PTR_W'(wrap_inc(int'(rd_ptr_q), DEPTH));
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (!error_valid_q && cfg_err) begin
                error_valid_q <= 1'b1;
                error_code_q  <= CFG_TEMPORAL_FIFO_CAP_GT_DEPTH;
            end
        end
    end

    fabric_tag_occupancy #(.NUM_TAGS(NUM_TAGS), .CNT_W(CNT_W)) u_occ (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_tag_i (in_tag),
        .pop_i      (pop),
        .pop_tag_i  (out_tag),
        .tag_cnt_o  (tag_cnt)
    );

`ifndef SYNTHESIS
    // Handshake sanity: never overfill or over-drain the ring.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && count_q == DEPTH_C)) else $error("push while full");
            assert (!(pop && count_q == '0)) else $error("pop while empty");
        end
    end
`endif

endmodule

// File: tb/tb_fabric_temporal_fifo.sv
// tb_fabric_temporal_fifo: directed and random checks of the temporal FIFO against a queue model
module tb_fabric_temporal_fifo;

    localparam int DW = 32, TW = 4, DEPTH = 4, NT = 16, CW = 3, PW = 36;
    localparam logic [15:0] CODE_CAP = 16'h0007;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic [NT*CW-1:0] cfg_data = '0;
    logic in_ready, out_valid, error_valid;
    logic [PW-1:0] out_data;
    logic [15:0] error_code;

    int n_cmp = 0, n_bad = 0;
    int caps [NT];
    logic [PW-1:0] q [$];
    logic exp_ev = 1'b0;
    logic [15:0] exp_ec = '0;

    always #5 clk = ~clk;

    fabric_temporal_fifo #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .cfg_data_i(cfg_data), .error_valid_o(error_valid), .error_code_o(error_code)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_cap(input int t, input int v);
        caps[t] = v;
        cfg_data[t*CW +: CW] = CW'(v);
    endtask

    function automatic int resident(input int t);
        int n = 0;
        foreach (q[i]) if (int'(q[i][DW +: TW]) == t) n++;
        return n;
    endfunction

    // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
    task automatic tick();
        int tag;
        logic exp_rdy, do_push, do_pop, bad;
        @(negedge clk);
        tag = int'(in_data[DW +: TW]);
        exp_rdy = q.size() < DEPTH && (caps[tag] == 0 || resident(tag) < caps[tag]);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) chk("out_data", 64'(out_data), 64'(q[0]));
        chk("count", 64'(dut.count_q), 64'(q.size()));
        chk("error_valid", 64'(error_valid), 64'(exp_ev));
        chk("error_code", 64'(error_code), 64'(exp_ec));
        do_push = in_valid && exp_rdy;
        do_pop = out_ready && q.size() != 0;
        bad = 1'b0;
        foreach (caps[t]) if (caps[t] > DEPTH) bad = 1'b1;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            exp_ev = 1'b0;
            exp_ec = '0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(in_data);
            if (!exp_ev && bad) begin
                exp_ev = 1'b1;
                exp_ec = CODE_CAP;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input int tag, input logic [31:0] d, input logic r);
        in_valid = v;
        in_data = {TW'(tag), d};
        out_ready = r;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        foreach (caps[t]) caps[t] = 0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        // reset state
        drive(1'b0, 0, 0, 1'b0);
        // T1 ordering and one-cycle latency
        drive(1'b1, 2, 32'hA, 1'b1);
        chk("t1_first_visible", 64'(out_data), 64'h2_0000000A);
        drive(1'b1, 5, 32'hB, 1'b1);
        drive(1'b1, 2, 32'hC, 1'b1);
        repeat (3) drive(1'b0, 0, 0, 1'b1);
        // T2 full, one pop, then wrap
        for (int i = 0; i < 5; i++) drive(1'b1, i, 32'h100 + i, 1'b0);
        chk("t2_full_blocks", 64'(in_ready), 64'd0);
        drive(1'b1, 7, 32'h200, 1'b1);
        drive(1'b1, 7, 32'h201, 1'b0);
        for (int i = 0; i < 12; i++) drive(i % 3 != 2, i % 16, 32'h300 + i, 1'b1);
        repeat (5) drive(1'b0, 0, 0, 1'b1);
        // T3 per-tag cap
        set_cap(3, 2);
        for (int i = 0; i < 3; i++) drive(1'b1, 3, 32'h400 + i, 1'b0);
        chk("t3_cap_stall", 64'(in_ready), 64'd0);
        drive(1'b1, 1, 32'h410, 1'b0);
        drive(1'b1, 3, 32'h402, 1'b1);
        drive(1'b1, 3, 32'h402, 1'b0);
        repeat (5) drive(1'b0, 0, 0, 1'b1);
        set_cap(3, 0);
        // T4 simultaneous push and pop of one tag
        drive(1'b1, 4, 32'h500, 1'b0);
        drive(1'b1, 4, 32'h501, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 4, 32'h510 + i, 1'b1);
        chk("t4_count_stable", 64'(dut.count_q), 64'd2);
        repeat (3) drive(1'b0, 0, 0, 1'b1);
        // T5 config error is sticky
        set_cap(0, 5);
        drive(1'b0, 0, 0, 1'b0);
        drive(1'b1, 6, 32'h600, 1'b0);
        set_cap(0, 0);
        repeat (3) drive(1'b1, 6, 32'h601, 1'b1);
        chk("t5_sticky", 64'(error_code), 64'(CODE_CAP));
        // T6 reset mid-stream
        repeat (3) drive(1'b1, 9, 32'h700, 1'b0);
        do_reset();
        drive(1'b0, 0, 0, 1'b1);
        chk("t6_no_old_data", 64'(out_valid), 64'd0);
        // random traffic with changing caps and occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) set_cap($urandom_range(0, 3), $urandom_range(0, 4));
            if ($urandom_range(0, 149) == 0) set_cap($urandom_range(0, 15), 5);
            if ($urandom_range(0, 99) == 0) do_reset();
            else drive(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom, $urandom_range(0, 3) != 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
